// File: rtl/hazard_scoreboard_unit_if.sv
// Decode-side hazard bundle: ID decode fields, MEM/EX status in; stall, bubble, flush, counters out.
interface hazard_scoreboard_unit_if #(
  parameter int REG_W   = 4,
  parameter int MAX_OUT = 2,
  parameter int CNT_W   = 16
);
  localparam int OCC_W = $clog2(MAX_OUT + 1);

  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_rs_used;
  logic             id_rt_used;
  logic             id_is_load;
  logic [REG_W-1:0] id_dst;
  logic             mem_done;
  logic             mem_busy;
  logic             ex_branch_taken;
  logic             stall;
  logic             set_ctrl_zero;
  logic             flush_if_id;
  logic [CNT_W-1:0] stall_cnt;
  logic [OCC_W-1:0] outstanding;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_is_load, id_dst,
    output mem_done, mem_busy, ex_branch_taken,
    input  stall, set_ctrl_zero, flush_if_id, stall_cnt, outstanding
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_is_load, id_dst,
    input  mem_done, mem_busy, ex_branch_taken,
    output stall, set_ctrl_zero, flush_if_id, stall_cnt, outstanding
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// Load-use scoreboard with in-order FIFO of outstanding load destinations; outputs are zero-latency.
// Backpressure: stalls decode on RAW hazards or a full FIFO; mem_busy freezes everything.
module hazard_scoreboard_unit #(
  parameter int REG_W      = 4,
  parameter int MAX_OUT    = 2,
  parameter int FWD_BYPASS = 1,
  parameter int REG0_ZERO  = 1,
  parameter int CNT_W      = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  hazard_scoreboard_unit_if.slave hz
);
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int OCC_W = $clog2(MAX_OUT + 1);
  localparam int NREG  = 2 ** REG_W;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [MAX_OUT-1:0] vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wen_q [MAX_OUT];
  logic [REG_W-1:0] dst_q [MAX_OUT];

  logic [NREG-1:0] busy_vec;
  logic            raw, full_stall, stall, push, pop, push_wen;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // With forwarding, the load returning this cycle no longer blocks its consumers.
  always_comb begin
    busy_vec = '0;
    for (int i = 0; i < MAX_OUT; i++) begin
      if (vld_q[i] && wen_q[i] &&
          !(FWD_BYPASS != 0 && hz.mem_done && PTR_W'(i) == rd_ptr_q))
        busy_vec[dst_q[i]] = 1'b1;
    end
    if (REG0_ZERO != 0) busy_vec[0] = 1'b0;
  end

  assign raw = hz.id_valid & ((hz.id_rs_used & busy_vec[hz.id_rs]) |
                              (hz.id_rt_used & busy_vec[hz.id_rt]));
  assign full_stall = hz.id_valid & hz.id_is_load &
                      (occ_q == OCC_W'(MAX_OUT)) & ~hz.mem_done;

  assign stall = hz.mem_busy | ((raw | full_stall) & ~hz.ex_branch_taken);
  assign hz.stall         = stall;
  assign hz.set_ctrl_zero = ~hz.mem_busy & (raw | full_stall | hz.ex_branch_taken);
  assign hz.flush_if_id   = hz.ex_branch_taken & ~hz.mem_busy;
  assign hz.stall_cnt     = cnt_q;
  assign hz.outstanding   = occ_q;

  assign push     = hz.id_valid & hz.id_is_load & ~stall & ~hz.ex_branch_taken & ~hz.mem_busy;
  assign pop      = hz.mem_done & ~hz.mem_busy & (occ_q != '0);
  assign push_wen = !(REG0_ZERO != 0 && hz.id_dst == '0);

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    occ_d    = occ_q;
    if (push && !pop) occ_d = occ_q + OCC_W'(1);
    if (pop && !push) occ_d = occ_q - OCC_W'(1);
    // Clear before set: a push into a full FIFO reuses the slot being popped.
    vld_d = vld_q;
    if (pop)  vld_d[rd_ptr_q] = 1'b0;
    if (push) vld_d[wr_ptr_q] = 1'b1;
    cnt_d = cnt_q;
    if (stall && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      vld_q    <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      vld_q    <= vld_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wen_q[wr_ptr_q] <= push_wen;
      dst_q[wr_ptr_q] <= hz.id_dst;
    end
  end
endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised successor to the single-cycle load-use detector in the decode stage.
- Tracks up to MAX_OUT outstanding loads in an in-order destination FIFO, so a variable-latency data memory is supported.
- Generates the decode-stage stall and bubble, the taken-branch flushes, and a saturating stall-cycle counter.
- Sits beside the ID stage. It is fed by ID decode fields, the MEM-stage completion strobe and the EX branch-resolution signal.

Parameters:
- REG_W, 4, register-index width; register file has 2**REG_W entries.
- MAX_OUT, 2, maximum outstanding loads (FIFO depth, >=1).
- FWD_BYPASS, 1, 1 = a load completing this cycle does not cause a hazard (MEM/WB forwarding exists); 0 = dependent waits one extra cycle.
- REG0_ZERO, 1, 1 = register 0 is hardwired and never creates a hazard.
- CNT_W, 16, stall-counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_rs  in  REG_W  source 1 index.
- id_rt  in  REG_W  source 2 index.
- id_rs_used  in  1  source 1 is read.
- id_rt_used  in  1  source 2 is read.
- id_is_load  in  1  ID instruction is a load.
- id_dst  in  REG_W  load destination.
- mem_done  in  1  oldest outstanding load returns data this cycle.
- mem_busy  in  1  memory not ready; whole pipe frozen.
- ex_branch_taken  in  1  branch resolved taken in EX.
- stall  out  1  1 = hold PC and IF/ID.
- set_ctrl_zero  out  1  1 = insert bubble into ID/EX.
- flush_if_id  out  1  squash IF/ID.
- stall_cnt  out  CNT_W  cycles with stall=1, saturating.
- outstanding  out  clog2(MAX_OUT+1)  current FIFO occupancy.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty, pointers 0, outstanding=0, stall_cnt=0.
  - Combinational outputs then evaluate to stall=0, set_ctrl_zero=0, flush_if_id=0 for any inputs except mem_busy/ex_branch_taken.
- FIFO entry = {wen, dst}. wen=0 when REG0_ZERO=1 and id_dst=0.
- Pointers wrap modulo MAX_OUT. Occupancy counter distinguishes full from empty.
- busy(r) = some valid entry with wen=1 and dst==r.
  - With FWD_BYPASS=1, the head entry is excluded when mem_done=1.
  - With REG0_ZERO=1, busy(0)=0.
- raw = id_valid & ((id_rs_used & busy(id_rs)) | (id_rt_used & busy(id_rt))).
- full_stall = id_valid & id_is_load & (outstanding==MAX_OUT) & ~mem_done.
- All outputs are combinational from registered state and current inputs (zero latency).
  - stall = mem_busy | ((raw | full_stall) & ~ex_branch_taken).
  - set_ctrl_zero = ~mem_busy & (raw | full_stall | ex_branch_taken).
  - flush_if_id = ex_branch_taken & ~mem_busy.
- Push on rising edge when id_valid & id_is_load & ~stall & ~ex_branch_taken & ~mem_busy.
- Pop when mem_done.
- Push and pop in the same cycle: occupancy unchanged, both pointers advance.
- mem_done with an empty FIFO: ignored, no underflow.
- mem_done together with mem_busy: protocol violation; the bench asserts it never occurs. RTL gives mem_busy priority and does not pop.
- Branch flush does not cancel loads already in the FIFO (older than the branch). The squashed ID load is not pushed.
- stall_cnt increments each cycle stall=1 and holds at 2**CNT_W-1.
- The FIFO depth bound guarantees no overflow: a push is never accepted while full unless a pop happens in the same cycle.

Test Plan:
- Load-use hazard, FWD_BYPASS=1.
  - Stimulus: load r3 issues; next cycle ID add reads r3, mem_done=0 for 2 cycles, then 1.
  - Required: stall=set_ctrl_zero=1 for 2 cycles, 0 in the mem_done cycle; stall_cnt=2.
- Same sequence with FWD_BYPASS=0.
  - Required: stall for 3 cycles; the add passes the cycle after mem_done.
- Full FIFO, MAX_OUT=2.
  - Stimulus: loads r1, r2 outstanding; third load r4 in ID.
  - Required: stall=1, outstanding=2. On mem_done, the third load pushes the same cycle and outstanding stays 2.
- Register 0 and unused sources.
  - Stimulus: load r0 outstanding, ID reads r0; load r5 outstanding, ID has id_rt=5 with id_rt_used=0.
  - Required: stall=0 in both cases.
- Branch and memory freeze.
  - Stimulus: ex_branch_taken=1 with a raw hazard in ID.
  - Required: flush_if_id=1, set_ctrl_zero=1, stall=0, no push.
  - Stimulus: mem_busy=1.
  - Required: stall=1, set_ctrl_zero=0, flush_if_id=0, FIFO unchanged.
- Asynchronous reset mid-operation.
  - Stimulus: assert rst_n=0 with 2 outstanding loads, between clock edges.
  - Required: outstanding=0 and stall_cnt=0 immediately; r1 read afterwards gives no stall.
